// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: per-key FSM state encoding and default debounce/long-press thresholds.
package key_debounce_pkg;

  localparam int unsigned DEBOUNCE_N_DEF = 4;
  localparam int unsigned LONG_N_DEF     = 8;

  typedef logic [1:0] key_st_t;

  localparam key_st_t ST_IDLE      = 2'd0;
  localparam key_st_t ST_PRESS_CHK = 2'd1;
  localparam key_st_t ST_PRESSED   = 2'd2;
  localparam key_st_t ST_REL_CHK   = 2'd3;

endpackage

// File: rtl/key_debounce_fsm.sv
// Per-key synchronizer, debounce FSM and press/release/long event pulses.
// Long-press counting is built only when KEY_LONG_PRESS_EN is defined; otherwise key_long is tied low.
module key_debounce_fsm
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_N = DEBOUNCE_N_DEF,
  parameter int unsigned LONG_N     = LONG_N_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

  if (DEBOUNCE_N < 1 || DEBOUNCE_N > 15 || LONG_N < 1 || LONG_N > 255) begin : g_param_err
    $error("key_debounce_fsm: DEBOUNCE_N or LONG_N out of range");
  end

  logic             sync_q1;
  logic             sync_q2;
  logic             pressed_c;
  key_st_t          state;
  key_st_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             key_state_nxt;
  logic             press_nxt;
  logic             release_nxt;

  // Two-flop synchronizer; idles at "released"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  assign pressed_c = ~sync_q2;
  assign cnt_inc_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_state   <= key_state_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

  // Debounce transitions, evaluated only on sample ticks
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    key_state_nxt = key_state;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (pressed_c) begin
            if (DEBOUNCE_N == 1) begin
              state_nxt     = ST_PRESSED;
              key_state_nxt = 1'b1;
              press_nxt     = 1'b1;
            end else begin
              state_nxt = ST_PRESS_CHK;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_PRESS_CHK: begin
          if (!pressed_c) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (cnt >= CNT_LAST) begin
            state_nxt     = ST_PRESSED;
            cnt_nxt       = '0;
            key_state_nxt = 1'b1;
            press_nxt     = 1'b1;
          end else begin
            cnt_nxt = cnt_inc_c;
          end
        end
        ST_PRESSED: begin
          if (!pressed_c) begin
            if (DEBOUNCE_N == 1) begin
              state_nxt     = ST_IDLE;
              key_state_nxt = 1'b0;
              release_nxt   = 1'b1;
            end else begin
              state_nxt = ST_REL_CHK;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_REL_CHK: begin
          if (pressed_c) begin
            state_nxt = ST_PRESSED;
            cnt_nxt   = '0;
          end else if (cnt >= CNT_LAST) begin
            state_nxt     = ST_IDLE;
            cnt_nxt       = '0;
            key_state_nxt = 1'b0;
            release_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt_inc_c;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LONG_W = $clog2(LONG_N + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_N);

  logic [LONG_W-1:0] long_cnt;
  logic [LONG_W-1:0] long_cnt_nxt;
  logic              long_nxt;

  // Held-tick count restarts on every fresh press and saturates at LONG_N
  always_comb begin
    long_cnt_nxt = long_cnt;
    long_nxt     = 1'b0;
    if (press_nxt) begin
      long_cnt_nxt = '0;
    end else if (tick && (state == ST_PRESSED || state == ST_REL_CHK) && long_cnt != LONG_MAX) begin
      long_cnt_nxt = long_cnt + LONG_W'(1);
      long_nxt     = (long_cnt_nxt == LONG_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt <= '0;
      key_long <= 1'b0;
    end else begin
      long_cnt <= long_cnt_nxt;
      key_long <= long_nxt;
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_scan.sv
// Multi-key debouncer: shared sample-tick counter feeding one key_debounce_fsm per key.
// Define KEY_LONG_PRESS_EN to enable key_long pulses; otherwise key_long stays 0.
module key_debounce_scan
  import key_debounce_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = 4,
  parameter logic [23:0] SAMPLE_TOP = 24'd15,
  parameter int unsigned DEBOUNCE_N = DEBOUNCE_N_DEF,
  parameter int unsigned LONG_N     = LONG_N_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_WIDTH-1:0] key_n,
  output logic [KEY_WIDTH-1:0] key_state,
  output logic [KEY_WIDTH-1:0] key_press,
  output logic [KEY_WIDTH-1:0] key_release,
  output logic [KEY_WIDTH-1:0] key_long
);

  localparam int unsigned TICK_W = (SAMPLE_TOP == 24'd0) ? 1 : $clog2(int'(SAMPLE_TOP) + 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;

  assign tick_c = (tick_cnt == TICK_W'(SAMPLE_TOP));

  // Free-running sample period counter, 0..SAMPLE_TOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  for (genvar i = 0; i < int'(KEY_WIDTH); i++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_N (DEBOUNCE_N),
      .LONG_N     (LONG_N)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick_c),
      .key_n       (key_n[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule
